// File: rtl/fft_sink_packetizer.sv
// fft_sink_packetizer
// Transmit-side framer for the FFT II core's Avalon-ST sink. A sample stream
// that cannot be stalled is buffered in a small show-ahead FIFO. The block
// emits FFT_LEN-beat packets with sop/eop framing and respects sink_ready
// with a ready latency of 0.
//
// Ports:
//   clk_clk, rst_reset_n        : clock and synchronous active-low reset
//   enable                      : 1 = start/continue framing, 0 = stop after current packet
//   in_valid, in_real, in_imag  : input sample strobe and signed components (no back-pressure)
//   src_valid/ready/error/sop/eop/data : Avalon-ST source to the FFT sink
//   overflow, ovf_clear         : sticky "sample dropped" flag and its clear
//   busy                        : a packet is in progress
//   frame_count                 : completed packets, wraps modulo 2^16
module fft_sink_packetizer #(
    parameter int DATA_W     = 24,
    parameter int FFT_LEN    = 1024,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk_clk,
    input  logic                  rst_reset_n,
    input  logic                  enable,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_real,
    input  logic [DATA_W-1:0]     in_imag,
    output logic                  src_valid,
    input  logic                  src_ready,
    output logic [1:0]            src_error,
    output logic                  src_sop,
    output logic                  src_eop,
    output logic [2*DATA_W-1:0]   src_data,
    output logic                  overflow,
    input  logic                  ovf_clear,
    output logic                  busy,
    output logic [15:0]           frame_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(FFT_LEN);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [2*DATA_W-1:0] mem_r [FIFO_DEPTH];
    logic [AW-1:0]       rd_ptr_r;
    logic [AW-1:0]       wr_ptr_r;
    logic [AW:0]         count_r;
    logic [IW-1:0]       index_r;
    logic [IW-1:0]       index_next_s;
    logic [AW-1:0]       rd_ptr_next_s;
    logic [AW:0]         count_vis_s;
    logic                pop_s;
    logic                push_s;
    logic                drop_s;
    logic                last_s;
    logic                valid_next_s;

    logic                src_valid_r;
    logic                src_sop_r;
    logic                src_eop_r;
    logic [2*DATA_W-1:0] src_data_r;
    logic                overflow_r;
    logic                busy_r;
    logic [15:0]         frame_count_r;

    assign src_valid   = src_valid_r;
    assign src_sop     = src_sop_r;
    assign src_eop     = src_eop_r;
    assign src_data    = src_data_r;
    assign src_error   = 2'b00;
    assign overflow    = overflow_r;
    assign busy        = busy_r;
    assign frame_count = frame_count_r;

    // Handshake, FIFO push/drop decisions and next FSM/index values.
    always_comb begin
        pop_s         = src_valid_r && src_ready;
        push_s        = in_valid && ((count_r < (AW+1)'(FIFO_DEPTH)) || pop_s);
        drop_s        = in_valid && !push_s;
        last_s        = pop_s && (index_r == IW'(FFT_LEN - 1));
        rd_ptr_next_s = rd_ptr_r + AW'(pop_s);
        // Entries visible at the head next cycle: this cycle's push is
        // deliberately excluded so a new sample never falls through.
        count_vis_s   = count_r - (AW+1)'(pop_s);

        if (last_s) begin
            index_next_s = {IW{1'b0}};
        end else if (pop_s) begin
            index_next_s = index_r + {{(IW-1){1'b0}}, 1'b1};
        end else begin
            index_next_s = index_r;
        end

        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_next_s = ST_SEND;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (last_s && !enable) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase

        valid_next_s = (state_next_s == ST_SEND) && (count_vis_s != {(AW+1){1'b0}});
    end

    // Sample storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {in_real, in_imag};
        end
    end

    // FSM, FIFO pointers, status and registered source outputs.
    always_ff @(posedge clk_clk) begin
        if (!rst_reset_n) begin
            state_r       <= ST_IDLE;
            rd_ptr_r      <= {AW{1'b0}};
            wr_ptr_r      <= {AW{1'b0}};
            count_r       <= {(AW+1){1'b0}};
            index_r       <= {IW{1'b0}};
            src_valid_r   <= 1'b0;
            src_sop_r     <= 1'b0;
            src_eop_r     <= 1'b0;
            src_data_r    <= {(2*DATA_W){1'b0}};
            overflow_r    <= 1'b0;
            busy_r        <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            state_r  <= state_next_s;
            index_r  <= index_next_s;
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_vis_s + (AW+1)'(push_s);
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end

            // Outputs reflect the post-edge state; with no pop the head and
            // index are unchanged, so a stalled beat holds stable.
            src_valid_r <= valid_next_s;
            src_sop_r   <= valid_next_s && (index_next_s == {IW{1'b0}});
            src_eop_r   <= valid_next_s && (index_next_s == IW'(FFT_LEN - 1));
            if (count_vis_s != {(AW+1){1'b0}}) begin
                src_data_r <= mem_r[rd_ptr_next_s];
            end else begin
                src_data_r <= src_data_r;
            end
            busy_r <= (state_next_s == ST_SEND);

            // A drop in the same cycle as a clear wins.
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clear) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end

            if (last_s) begin
                frame_count_r <= frame_count_r + 16'd1;
            end else begin
                frame_count_r <= frame_count_r;
            end
        end
    end

endmodule

// File: tb/tb_fft_sink_packetizer.sv
// tb_fft_sink_packetizer
// Self-checking bench: directed phases followed by randomized traffic, all
// compared every cycle against a queue-based packet model.
module tb_fft_sink_packetizer;

    localparam int DATA_W     = 24;
    localparam int FFT_LEN    = 8;
    localparam int FIFO_DEPTH = 16;

    logic                clk_clk;
    logic                rst_reset_n;
    logic                enable;
    logic                in_valid;
    logic [DATA_W-1:0]   in_real;
    logic [DATA_W-1:0]   in_imag;
    logic                src_valid;
    logic                src_ready;
    logic [1:0]          src_error;
    logic                src_sop;
    logic                src_eop;
    logic [2*DATA_W-1:0] src_data;
    logic                overflow;
    logic                ovf_clear;
    logic                busy;
    logic [15:0]         frame_count;

    fft_sink_packetizer #(
        .DATA_W(DATA_W), .FFT_LEN(FFT_LEN), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk_clk(clk_clk), .rst_reset_n(rst_reset_n), .enable(enable),
        .in_valid(in_valid), .in_real(in_real), .in_imag(in_imag),
        .src_valid(src_valid), .src_ready(src_ready), .src_error(src_error),
        .src_sop(src_sop), .src_eop(src_eop), .src_data(src_data),
        .overflow(overflow), .ovf_clear(ovf_clear), .busy(busy),
        .frame_count(frame_count)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // Reference model: a queue of stored samples plus packet bookkeeping.
    logic [2*DATA_W-1:0] m_q[$];
    int                  m_vis;      // samples the sink may already see
    int                  m_idx;      // beat number within the packet
    int                  m_frames;
    bit                  m_sending;
    bit                  m_ovf;
    int                  ramp;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cycle, obs, exp);
        end
    endtask

    function automatic bit m_valid();
        return m_sending && (m_vis > 0);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_vis = 0; m_idx = 0; m_frames = 0; m_sending = 1'b0; m_ovf = 1'b0;
    endtask

    // One clock: compare at the falling edge, then drive inputs and advance
    // the model to what must hold after the next rising edge.
    task automatic step(input bit rst_n_i, input bit en_i, input bit iv_i,
                        input bit rdy_i, input bit clr_i);
        bit                  xfer;
        logic [2*DATA_W-1:0] smp;
        @(negedge clk_clk);
        cycle++;
        check_val("valid", 64'(src_valid), 64'(m_valid()));
        check_val("sop", 64'(src_sop), 64'(m_valid() && m_idx == 0));
        check_val("eop", 64'(src_eop), 64'(m_valid() && m_idx == FFT_LEN - 1));
        check_val("busy", 64'(busy), 64'(m_sending));
        check_val("overflow", 64'(overflow), 64'(m_ovf));
        check_val("frame_count", 64'(frame_count), 64'(m_frames & 16'hFFFF));
        check_val("error", 64'(src_error), 64'd0);
        if (m_valid()) begin
            check_val("data", 64'(src_data), 64'(m_q[0]));
        end

        smp = {ramp[DATA_W-1:0], 24'(-ramp)};
        rst_reset_n = rst_n_i;
        enable      = en_i;
        in_valid    = iv_i;
        src_ready   = rdy_i;
        ovf_clear   = clr_i;
        in_real     = smp[2*DATA_W-1:DATA_W];
        in_imag     = smp[DATA_W-1:0];
        if (iv_i) ramp++;

        if (!rst_n_i) begin
            model_reset();
            return;
        end
        xfer = m_valid() && rdy_i;
        if (m_sending) begin
            if (xfer) begin
                void'(m_q.pop_front());
                m_idx++;
                if (m_idx == FFT_LEN) begin
                    m_idx = 0;
                    m_frames++;
                    if (!en_i) m_sending = 1'b0;
                end
            end
        end else if (en_i) begin
            m_sending = 1'b1;
        end
        m_vis = m_q.size();
        if (iv_i) begin
            if (m_q.size() < FIFO_DEPTH) begin
                m_q.push_back(smp);
            end else begin
                m_ovf = 1'b1;
            end
        end
        if (!(iv_i && m_q.size() >= FIFO_DEPTH && m_vis == FIFO_DEPTH) && clr_i && !(iv_i && m_vis >= FIFO_DEPTH)) begin
            m_ovf = 1'b0;
        end
    endtask

    initial begin
        int n;
        rst_reset_n = 1'b0; enable = 1'b0; in_valid = 1'b0; src_ready = 1'b0;
        ovf_clear = 1'b0; in_real = '0; in_imag = '0;
        ramp = 0;
        model_reset();
        repeat (2) @(posedge clk_clk);

        // Continuous ramp, always ready: back-to-back packets.
        for (int i = 0; i < 40; i++) step(1, 1, 1, 1, 0);
        // Ready toggling: FIFO absorbs the rate difference and eventually drops.
        for (int i = 0; i < 40; i++) step(1, 1, 1, (i % 2) == 0, 0);
        // Drain, then 20 pushes into a stalled sink: 4 drops.
        for (int i = 0; i < 30; i++) step(1, 1, 0, 1, 1);
        for (int i = 0; i < 20; i++) step(1, 1, 1, 0, 0);
        for (int i = 0; i < 30; i++) step(1, 1, 0, 1, 0);
        step(1, 1, 0, 1, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 1, 0);

        // Deassert enable at beat 3 of a packet; it must still complete.
        n = 0;
        while (!(m_valid() && m_idx == 3) && n < 60) begin
            step(1, 1, 1, 1, 0); n++;
        end
        check_val("wait_beat3", 64'(n >= 60), 64'd0);
        for (int i = 0; i < 20; i++) step(1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 1);

        // Input gap of 5 cycles mid-packet.
        for (int i = 0; i < 12; i++) step(1, 1, 1, 1, 1);
        for (int i = 0; i < 30; i++) step(1, 1, i < 5 || i >= 10 ? 1'b1 : 1'b0, 1, 0);

        // Reset at beat 5, then restart.
        n = 0;
        while (!(m_valid() && m_idx == 5) && n < 60) begin
            step(1, 1, 1, 1, 0); n++;
        end
        check_val("wait_beat5", 64'(n >= 60), 64'd0);
        step(0, 1, 1, 1, 0);
        for (int i = 0; i < 20; i++) step(1, 1, 1, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom % 600) != 0, ($urandom % 20) != 0, ($urandom % 4) != 0,
                 ($urandom % 3) != 0, ($urandom % 40) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
